// File: rtl/tdm_pkg.sv
// Shared constants and FSM state type for the 32-channel TDM demultiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdm_pkg;
  localparam int NCH = 32;
  localparam int CW  = 5;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;
endpackage

// File: rtl/tdm_demux32_if.sv
// Serial TDM input, parallel frame output and status signals of the demux.
// Latency: n/a (signal bundle only).
// Backpressure: out_valid/out_ready on the frame side; the serial side has none.
interface tdm_demux32_if;
  import tdm_pkg::*;

  logic           din;
  logic           din_valid;
  logic           sync;
  logic [NCH-1:0] dout;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  ch_cnt;
  logic           locked;
  logic           overrun;
  logic           sync_err;

  // Source/consumer side: drives the serial stream and frame acceptance.
  modport master (
    output din, din_valid, sync, out_ready,
    input  dout, out_valid, ch_cnt, locked, overrun, sync_err
  );

  // Demux side.
  modport slave (
    input  din, din_valid, sync, out_ready,
    output dout, out_valid, ch_cnt, locked, overrun, sync_err
  );
endinterface

// File: rtl/demux1x32.sv
// Combinational 1-to-32 decoder producing the shadow-register write enables.
// Latency: zero cycles (purely combinational).
// Backpressure: none; all-zero output when en is low.
module demux1x32
  import tdm_pkg::*;
(
  input  logic [CW-1:0]  sel,
  input  logic           en,
  output logic [NCH-1:0] onehot
);

  // Exactly one enable bit when en is high, none otherwise.
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux32.sv
// Serial-to-parallel TDM demux: collects 32 channel bits into a frame, hands it off on out_valid/out_ready.
// Latency: dout/out_valid update on the edge that samples the channel-31 bit.
// Backpressure: a completed frame arriving while an unconsumed one is held is dropped and flagged via overrun.
module tdm_demux32 #(
  parameter int NCH = tdm_pkg::NCH,
  parameter int CW  = tdm_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux32_if.slave  bus
);
  import tdm_pkg::*;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_ch_cnt;
  logic [CW-1:0]  w_ch_cnt_nxt;
  logic [CW-1:0]  w_sel;
  logic [NCH-1:0] r_shadow;
  logic [NCH-1:0] r_dout;
  logic [NCH-1:0] w_onehot;
  logic [NCH-1:0] w_frame;
  logic           r_out_valid;
  logic           r_overrun;
  logic           r_sync_err;
  logic           w_accept;
  logic           w_frame_done;
  logic           w_load;
  logic           w_out_valid_nxt;
  logic           w_overrun_nxt;
  logic           w_sync_err_nxt;

  // Write-enable decode: a sync always targets channel 0, otherwise the running counter.
  demux1x32 u_demux (
    .sel    (w_sel),
    .en     (w_accept),
    .onehot (w_onehot)
  );

  // Next-state, counter and frame hand-off decisions.
  always_comb begin
    w_state_nxt     = r_state;
    w_ch_cnt_nxt    = r_ch_cnt;
    w_sel           = bus.sync ? '0 : r_ch_cnt;
    // In HUNT only a sync-marked bit is taken; in RECV every valid bit is.
    w_accept        = bus.din_valid && ((r_state == RECV) || bus.sync);
    // A sync in the middle of a frame restarts it at channel 0.
    w_sync_err_nxt  = (r_state == RECV) && bus.din_valid && bus.sync && (r_ch_cnt != '0);
    w_frame_done    = w_accept && (w_sel == CW'(NCH - 1));
    // Channel-31 bit bypasses the shadow so the frame is ready on the same edge.
    w_frame         = {bus.din, r_shadow[NCH-2:0]};
    w_load          = w_frame_done && (!r_out_valid || bus.out_ready);
    w_overrun_nxt   = w_frame_done && r_out_valid && !bus.out_ready;
    w_out_valid_nxt = r_out_valid;

    if (w_load) begin
      w_out_valid_nxt = 1'b1;
    end else if (r_out_valid && bus.out_ready) begin
      w_out_valid_nxt = 1'b0;
    end

    if (w_accept) begin
      w_state_nxt  = RECV;
      w_ch_cnt_nxt = w_sel + 1'b1;
    end
  end

  // All state: FSM, counter, shadow, output frame and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_ch_cnt    <= '0;
      r_shadow    <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ch_cnt    <= w_ch_cnt_nxt;
      r_shadow    <= (r_shadow & ~w_onehot) | (w_onehot & {NCH{bus.din}});
      if (w_load) r_dout <= w_frame;
      r_out_valid <= w_out_valid_nxt;
      r_overrun   <= w_overrun_nxt;
      r_sync_err  <= w_sync_err_nxt;
    end
  end

  assign bus.dout      = r_dout;
  assign bus.out_valid = r_out_valid;
  assign bus.ch_cnt    = r_ch_cnt;
  assign bus.locked    = (r_state == RECV);
  assign bus.overrun   = r_overrun;
  assign bus.sync_err  = r_sync_err;

endmodule

// File: tb/tb_tdm_demux32.sv
// Directed bench for tdm_demux32: reset, framing, stalls, overrun, resync and mid-frame reset.
// Latency: outputs are sampled 1 time unit after the edge that consumed each bit.
// Backpressure: out_ready is driven per scenario.
module tb_tdm_demux32;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  tdm_demux32_if bus ();

  tdm_demux32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  // One valid bit; returns 1 unit after the edge that sampled it.
  task automatic send_bit(input logic b, input logic s);
    bus.din       = b;
    bus.sync      = s;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.din       = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] w, input logic use_sync);
    for (int i = 0; i < 32; i++) send_bit(w[i], use_sync && (i == 0));
  endtask

  task automatic test_reset();
    n_checks++; if (bus.dout !== 32'h0) begin n_errors++; $display("FAIL reset_dout: got %h exp 00000000", bus.dout); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.ch_cnt !== 5'd0) begin n_errors++; $display("FAIL reset_ch_cnt: got %0d exp 0", bus.ch_cnt); end
    n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked: got %b exp 0", bus.locked); end
    n_checks++; if (bus.overrun !== 1'b0 || bus.sync_err !== 1'b0) begin n_errors++; $display("FAIL reset_pulses: got ovr=%b serr=%b exp 0 0", bus.overrun, bus.sync_err); end
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    n_checks++; if (bus.ch_cnt !== 5'd0) begin n_errors++; $display("FAIL hunt_ignore_cnt: got %0d exp 0", bus.ch_cnt); end
    n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL hunt_ignore_locked: got %b exp 0", bus.locked); end
  endtask

  task automatic test_basic();
    logic [31:0] w;
    w = 32'hA5A5_0F0F;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i], i == 0);
      if (i == 0) begin
        n_checks++; if (bus.locked !== 1'b1) begin n_errors++; $display("FAIL basic_locked: got %b exp 1", bus.locked); end
        n_checks++; if (bus.ch_cnt !== 5'd1) begin n_errors++; $display("FAIL basic_cnt1: got %0d exp 1", bus.ch_cnt); end
      end
      if (i == 30) begin
        n_checks++; if (bus.out_valid !== 1'b0 || bus.dout !== 32'h0) begin n_errors++; $display("FAIL basic_partial: got vld=%b dout=%h exp 0 00000000", bus.out_valid, bus.dout); end
      end
    end
    n_checks++; if (bus.dout !== 32'hA5A50F0F) begin n_errors++; $display("FAIL basic_dout: got %h exp a5a50f0f", bus.dout); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_out_valid: got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL basic_overrun: got %b exp 0", bus.overrun); end
    n_checks++; if (bus.ch_cnt !== 5'd0) begin n_errors++; $display("FAIL basic_wrap: got %0d exp 0", bus.ch_cnt); end
    idle();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.dout !== 32'hA5A50F0F) begin n_errors++; $display("FAIL basic_consume: got vld=%b dout=%h exp 0 a5a50f0f", bus.out_valid, bus.dout); end
  endtask

  task automatic test_gaps();
    logic [31:0] w;
    logic [4:0]  exp_cnt;
    int          gap;
    w = 32'hA5A5_0F0F;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp_cnt = 5'(i);
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        idle();
        n_checks++; if (bus.ch_cnt !== exp_cnt) begin n_errors++; $display("FAIL gaps_stall_cnt: got %0d exp %0d", bus.ch_cnt, exp_cnt); end
      end
      send_bit(w[i], i == 0);
      exp_cnt = 5'(i + 1);
      n_checks++; if (bus.ch_cnt !== exp_cnt) begin n_errors++; $display("FAIL gaps_step_cnt: got %0d exp %0d", bus.ch_cnt, exp_cnt); end
    end
    n_checks++; if (bus.dout !== 32'hA5A50F0F) begin n_errors++; $display("FAIL gaps_dout: got %h exp a5a50f0f", bus.dout); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL gaps_out_valid: got %b exp 1", bus.out_valid); end
    idle();
  endtask

  task automatic test_overrun();
    logic [31:0] w;
    int          ov_count;
    w = 32'h1234_5678;
    ov_count = 0;
    bus.out_ready = 1'b0;
    send_frame(32'hFFFF_FFFF, 1'b1);
    n_checks++; if (bus.dout !== 32'hFFFFFFFF || bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_first: got vld=%b dout=%h exp 1 ffffffff", bus.out_valid, bus.dout); end
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i], i == 0);
      if (bus.overrun === 1'b1) ov_count++;
      if (i == 31) begin
        n_checks++; if (bus.overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_pulse: got %b exp 1", bus.overrun); end
      end
    end
    idle();
    n_checks++; if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_one_cycle: got %b exp 0", bus.overrun); end
    n_checks++; if (ov_count !== 1) begin n_errors++; $display("FAIL ovr_count: got %0d exp 1", ov_count); end
    n_checks++; if (bus.dout !== 32'hFFFFFFFF || bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_hold: got vld=%b dout=%h exp 1 ffffffff", bus.out_valid, bus.dout); end
    bus.out_ready = 1'b1;
    idle();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL ovr_consume: got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_sync_err();
    logic [31:0] w;
    int          se_count;
    w = 32'h0000_0001;
    se_count = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send_bit(1'b1, i == 0);
      if (bus.sync_err === 1'b1) se_count++;
    end
    n_checks++; if (bus.ch_cnt !== 5'd17) begin n_errors++; $display("FAIL serr_cnt17: got %0d exp 17", bus.ch_cnt); end
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i], i == 0);
      if (bus.sync_err === 1'b1) se_count++;
      if (i == 0) begin
        n_checks++; if (bus.sync_err !== 1'b1) begin n_errors++; $display("FAIL serr_pulse: got %b exp 1", bus.sync_err); end
        n_checks++; if (bus.ch_cnt !== 5'd1 || bus.locked !== 1'b1) begin n_errors++; $display("FAIL serr_restart: got cnt=%0d lock=%b exp 1 1", bus.ch_cnt, bus.locked); end
      end
    end
    n_checks++; if (se_count !== 1) begin n_errors++; $display("FAIL serr_count: got %0d exp 1", se_count); end
    n_checks++; if (bus.dout !== 32'h00000001 || bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL serr_dout: got vld=%b dout=%h exp 1 00000001", bus.out_valid, bus.dout); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    w = 32'h1234_5678;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) bus.out_ready = 1'b1;
      send_bit(w[i], 1'b0);
      if (i == 30) begin
        n_checks++; if (bus.dout !== 32'h00000001 || bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_hold: got vld=%b dout=%h exp 1 00000001", bus.out_valid, bus.dout); end
      end
    end
    n_checks++; if (bus.dout !== 32'h12345678) begin n_errors++; $display("FAIL b2b_dout: got %h exp 12345678", bus.dout); end
    n_checks++; if (bus.out_valid !== 1'b1 || bus.overrun !== 1'b0) begin n_errors++; $display("FAIL b2b_flags: got vld=%b ovr=%b exp 1 0", bus.out_valid, bus.overrun); end
    idle();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_consume: got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    bus.out_ready = 1'b0;
    send_frame(32'hDEAD_BEEF, 1'b1);
    n_checks++; if (bus.dout !== 32'hDEADBEEF || bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_pre: got vld=%b dout=%h exp 1 deadbeef", bus.out_valid, bus.dout); end
    for (int i = 0; i < 9; i++) send_bit(1'b1, i == 0);
    n_checks++; if (bus.ch_cnt !== 5'd9) begin n_errors++; $display("FAIL rmid_cnt9: got %0d exp 9", bus.ch_cnt); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.dout !== 32'h0 || bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_async_out: got vld=%b dout=%h exp 0 00000000", bus.out_valid, bus.dout); end
    n_checks++; if (bus.ch_cnt !== 5'd0 || bus.locked !== 1'b0) begin n_errors++; $display("FAIL rmid_async_fsm: got cnt=%0d lock=%b exp 0 0", bus.ch_cnt, bus.locked); end
    idle();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_bit(1'b1, 1'b0);
      if (bus.out_valid !== 1'b0 || bus.locked !== 1'b0 || bus.ch_cnt !== 5'd0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rmid_no_sync: got %0d bad cycles exp 0", bad); end
    send_frame(32'h0F0F_3C3C, 1'b1);
    n_checks++; if (bus.dout !== 32'h0F0F3C3C || bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_resync: got vld=%b dout=%h exp 1 0f0f3c3c", bus.out_valid, bus.dout); end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_sync_err();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
